// File: rtl/demux_collect4_1.sv
// demux_collect4_1: gathers four column beats of a 4-lane stream into a 4x4 tile
// and holds the tile under a valid/ready handshake until the consumer takes it.
module demux_collect4_1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_00,
    output logic [WIDTH-1:0] out_01,
    output logic [WIDTH-1:0] out_02,
    output logic [WIDTH-1:0] out_03,
    output logic [WIDTH-1:0] out_10,
    output logic [WIDTH-1:0] out_11,
    output logic [WIDTH-1:0] out_12,
    output logic [WIDTH-1:0] out_13,
    output logic [WIDTH-1:0] out_20,
    output logic [WIDTH-1:0] out_21,
    output logic [WIDTH-1:0] out_22,
    output logic [WIDTH-1:0] out_23,
    output logic [WIDTH-1:0] out_30,
    output logic [WIDTH-1:0] out_31,
    output logic [WIDTH-1:0] out_32,
    output logic [WIDTH-1:0] out_33,
    output logic [1:0]       col_idx
);
    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [WIDTH-1:0] tile_q [4][4];
    logic [WIDTH-1:0] tile_d [4][4];
    logic [WIDTH-1:0] lane [4];

    assign lane = '{in_data0, in_data1, in_data2, in_data3};

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        tile_d  = tile_q;
        if (clear) begin
            state_d = COLLECT;
            col_d   = 2'd0;
            tile_d  = '{default: '{default: '0}};
        end else if (state_q == COLLECT && in_valid) begin
            for (int r = 0; r < 4; r++) tile_d[r][col_q] = lane[r];
            col_d   = col_q + 2'd1;
            state_d = (col_q == 2'd3) ? HOLD : COLLECT;
        end else if (state_q == HOLD && out_ready) begin
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            col_q   <= 2'd0;
            tile_q  <= '{default: '{default: '0}};
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            tile_q  <= tile_d;
        end
    end

    // Handshake outputs depend on the state register only.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign col_idx   = col_q;

    assign out_00 = tile_q[0][0];
    assign out_01 = tile_q[0][1];
    assign out_02 = tile_q[0][2];
    assign out_03 = tile_q[0][3];
    assign out_10 = tile_q[1][0];
    assign out_11 = tile_q[1][1];
    assign out_12 = tile_q[1][2];
    assign out_13 = tile_q[1][3];
    assign out_20 = tile_q[2][0];
    assign out_21 = tile_q[2][1];
    assign out_22 = tile_q[2][2];
    assign out_23 = tile_q[2][3];
    assign out_30 = tile_q[3][0];
    assign out_31 = tile_q[3][1];
    assign out_32 = tile_q[3][2];
    assign out_33 = tile_q[3][3];
endmodule
